siso_shift_sequencer: RTL and testbench

- Sequences the external 8-bit serial-in/serial-out shift chain as a byte-wide loopback port.
- Each byte accepted over a valid/ready handshake is serialized MSB-first into the chain under a programmable shift-rate divider.
- The bits leaving the chain during those shifts are captured and returned as one output byte.
- Sits between the pad-level byte interface and the shift chain in the top-level tile.

---
 rtl/siso_shift_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_siso_shift_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/siso_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : siso_shift_sequencer
// Purpose  : Byte-wide loopback port in front of an external 8-stage
//            serial-in/serial-out shift chain. Each accepted byte is shifted
//            MSB-first into the chain at a programmable rate. The bits that
//            fall out of the chain during those shifts come back as one
//            output byte.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   cfg_div    in   shift period minus one, latched when a byte is accepted
//   in_data    in   byte to shift into the chain
//   in_valid   in   in_data valid
//   in_ready   out  sequencer accepts in_data this cycle
//   out_data   out  byte captured from the chain output
//   out_valid  out  out_data valid, held until out_ready
//   out_ready  in   consumer accepts out_data
//   flush      in   (SISO_FLUSH_EN only) clear the chain with DEPTH zero shifts
//   sr_din     out  serial data into the chain
//   sr_shift   out  chain shift enable; chain shifts on the edge ending this cycle
//   sr_dout    in   serial data from the chain's last stage
//   busy       out  high in any state other than IDLE
// Build option
//   SISO_FLUSH_EN : adds the flush port and the FLUSH state
// ============================================================================
module siso_shift_sequencer #(
    parameter int DEPTH = 8,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SISO_FLUSH_EN
    input  logic             flush,
`endif
    output logic             sr_din,
    output logic             sr_shift,
    input  logic             sr_dout,
    output logic             busy
);

    // One pulse counter serves both the 8-bit byte shift and the DEPTH-long
    // flush, so it is sized for whichever is longer.
    localparam int c_CNT_MAX = (DEPTH > 8) ? DEPTH : 8;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
`ifdef SISO_FLUSH_EN
        ,FLUSH = 2'd3
`endif
    } state_t;

    state_t             r_state;
    logic [7:0]         r_tx;
    logic [7:0]         r_cap;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [7:0]         r_out_data;
    logic               r_out_valid;

    logic               w_tick;
    logic               w_last_bit;
    logic               w_flush_req;

    assign w_tick     = (r_div_cnt == r_div);
    assign w_last_bit = (r_bit_cnt == c_CNT_W'(7));

`ifdef SISO_FLUSH_EN
    logic w_last_flush;
    assign w_last_flush = (r_bit_cnt == c_CNT_W'(DEPTH - 1));
    assign w_flush_req  = flush;
    assign sr_shift     = w_tick && ((r_state == SHIFT) || (r_state == FLUSH));
`else
    assign w_flush_req  = 1'b0;
    assign sr_shift     = w_tick && (r_state == SHIFT);
`endif

    // in_ready is gated by rst so it reads 0 during the reset cycle itself,
    // and by flush because a flush request wins over a pending byte.
    assign in_ready  = (r_state == IDLE) && !rst && !w_flush_req;
    // Taken straight from the tx register so it is already valid on the
    // shift cycle; zero in every other state, including FLUSH.
    assign sr_din    = (r_state == SHIFT) ? r_tx[7] : 1'b0;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tx        <= '0;
            r_cap       <= '0;
            r_div       <= '0;
            r_div_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // Consumer handshake; a reload from DONE below overrides this.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
`ifdef SISO_FLUSH_EN
                    if (flush) begin
                        r_div     <= cfg_div;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= FLUSH;
                    end else
`endif
                    if (in_valid) begin
                        r_tx      <= in_data;
                        r_div     <= cfg_div;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (w_tick) begin
                        r_div_cnt <= '0;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_tx      <= {r_tx[6:0], 1'b0};
                        r_cap     <= {r_cap[6:0], sr_dout};
                        if (w_last_bit) begin
                            r_state <= DONE;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end

                DONE: begin
                    // Free slot, or the held byte leaves this very edge.
                    if (!r_out_valid || out_ready) begin
                        r_out_data  <= r_cap;
                        r_out_valid <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

`ifdef SISO_FLUSH_EN
                FLUSH: begin
                    // Bits leaving the chain are deliberately not captured.
                    if (w_tick) begin
                        r_div_cnt <= '0;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (w_last_flush) begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
`endif

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_siso_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_siso_shift_sequencer
// Purpose  : Self-checking bench for siso_shift_sequencer. An 8-stage chain
//            is modelled around the DUT; expected bytes, pulse timing and
//            serial data come from a byte-level model of the chain contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_siso_shift_sequencer;

    localparam int DEPTH = 8;
    localparam int DIV_W = 4;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic [DIV_W-1:0] cfg_div   = '0;
    logic [7:0]       in_data   = '0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b1;
    logic             in_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             sr_din;
    logic             sr_shift;
    logic             sr_dout;
    logic             busy;
`ifdef SISO_FLUSH_EN
    logic             flush     = 1'b0;
`endif

    // Physical chain around the DUT (zero at power-up, never reset).
    logic [7:0] chain     = 8'h00;
    // Predicted chain contents as a whole byte.
    logic [7:0] mdl_chain = 8'h00;

    int total     = 0;
    int bad       = 0;
    int pulse_cnt = 0;
    logic [7:0] rx_q[$];

    siso_shift_sequencer #(
        .DEPTH (DEPTH),
        .DIV_W (DIV_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_div   (cfg_div),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SISO_FLUSH_EN
        .flush     (flush),
`endif
        .sr_din    (sr_din),
        .sr_shift  (sr_shift),
        .sr_dout   (sr_dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sr_shift) chain <= {chain[6:0], sr_din};
    end
    assign sr_dout = chain[7];

    always @(negedge clk) begin
        if (sr_shift) pulse_cnt <= pulse_cnt + 1;
        if (!rst && out_valid && out_ready) rx_q.push_back(out_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Present a byte and hold it until accepted; returns inside the first
    // cycle after the acceptance edge.
    task automatic accept(input logic [7:0] d, output bit ok);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_byte(input logic [7:0] d, input int div, input bit wiggle);
        int per, lim, npulse, first_ov;
        bit pos_ok, ok, rdy_at;
        logic [7:0] din_seq, got, exp_out;
        per = div + 1;
        lim = 8 * per + 4;
        npulse = 0; first_ov = -1; pos_ok = 1'b1; rdy_at = 1'b0;
        din_seq = '0; got = '0;
        exp_out = mdl_chain;
        out_ready = 1'b1;
        cfg_div = DIV_W'(div);
        accept(d, ok);
        if (wiggle) cfg_div = (div == 0) ? DIV_W'(15) : DIV_W'(0);
        total++;
        if (!ok) begin bad++; $display("FAIL accept: byte %h not accepted within bound", d); end
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (sr_shift) begin
                if (npulse < 8) din_seq[7 - npulse] = sr_din;
                if (k != per * (npulse + 1) - 1) pos_ok = 1'b0;
                npulse++;
            end
            if (out_valid && first_ov < 0) begin
                first_ov = k;
                got      = out_data;
                rdy_at   = in_ready;
            end
        end
        total++;
        if (npulse !== 8) begin bad++; $display("FAIL pulse_count: byte %h got %0d expected 8", d, npulse); end
        total++;
        if (pos_ok !== 1'b1) begin bad++; $display("FAIL pulse_spacing: byte %h div %0d got misplaced pulse expected period %0d", d, div, per); end
        total++;
        if (din_seq !== d) begin bad++; $display("FAIL sr_din_seq: got %h expected %h", din_seq, d); end
        total++;
        if (first_ov != 8 * per + 1) begin bad++; $display("FAIL out_valid_latency: got cycle %0d expected %0d", first_ov + 1, 8 * per + 2); end
        total++;
        if (got !== exp_out) begin bad++; $display("FAIL out_data: byte %h got %h expected %h", d, got, exp_out); end
        total++;
        if (rdy_at !== 1'b1) begin bad++; $display("FAIL in_ready_return: got %b expected 1", rdy_at); end
        mdl_chain = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_during: got %b expected 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++;
        if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        total++;
        if (sr_shift !== 1'b0 || sr_din !== 1'b0) begin bad++; $display("FAIL reset_serial: got shift=%b din=%b expected 0 0", sr_shift, sr_din); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        run_byte(8'hA5, 0, 1'b0);
        run_byte(8'h3C, 0, 1'b0);
    endtask

    task automatic test_divider();
        run_byte(8'hFF, 3, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [7:0] exp0;
        bit ok, stable;
        exp0 = mdl_chain;
        cfg_div = '0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        rx_q.delete();
        accept(8'h11, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_accept1: got timeout expected acceptance"); end
        repeat (12) @(posedge clk);
        accept(8'h22, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_accept2: got timeout expected acceptance"); end
        repeat (12) @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL bp_stall: got in_ready=%b busy=%b expected 0 1", in_ready, busy); end
        total++;
        if (out_valid !== 1'b1 || out_data !== exp0) begin bad++; $display("FAIL bp_hold: got valid=%b data=%h expected 1 %h", out_valid, out_data, exp0); end
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'h33;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_data !== exp0 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        total++;
        if (!stable) begin bad++; $display("FAIL bp_stable: got changing output expected %h held", exp0); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL bp_accept3: got timeout expected acceptance"); end
        repeat (16) @(negedge clk);
        total++;
        if (rx_q.size() != 3) begin
            bad++; $display("FAIL bp_count: got %0d bytes expected 3", rx_q.size());
        end else begin
            total++;
            if (rx_q[0] !== exp0 || rx_q[1] !== 8'h11 || rx_q[2] !== 8'h22) begin
                bad++;
                $display("FAIL bp_order: got %h %h %h expected %h 11 22", rx_q[0], rx_q[1], rx_q[2], exp0);
            end
        end
        mdl_chain = 8'h33;
    endtask

    task automatic test_reset_mid();
        int p0;
        bit ok;
        logic [7:0] d;
        d = 8'h96;
        cfg_div = '0;
        out_ready = 1'b1;
        p0 = pulse_cnt;
        accept(d, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rmid_accept: got timeout expected acceptance"); end
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (sr_shift !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rmid_state: got shift=%b valid=%b ready=%b busy=%b expected 0 0 1 0", sr_shift, out_valid, in_ready, busy);
        end
        total++;
        if (out_data !== 8'h00) begin bad++; $display("FAIL rmid_out_data: got %h expected 00", out_data); end
        repeat (12) @(negedge clk);
        #1;
        total++;
        if (pulse_cnt - p0 != 5) begin bad++; $display("FAIL rmid_pulses: got %0d expected 5", pulse_cnt - p0); end
        // Five bits of the aborted byte went into the chain.
        mdl_chain = 8'((mdl_chain << 5) | (d >> 3));
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            run_byte(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

`ifdef SISO_FLUSH_EN
    task automatic test_flush();
        int npulse;
        bit pos_ok, din_bad, ov_seen;
        run_byte(8'hFF, 0, 1'b0);
        cfg_div = DIV_W'(1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        npulse = 0; pos_ok = 1'b1; din_bad = 1'b0; ov_seen = 1'b0;
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            if (sr_shift) begin
                if (k != 2 * (npulse + 1) - 1) pos_ok = 1'b0;
                if (sr_din !== 1'b0) din_bad = 1'b1;
                npulse++;
            end
            if (out_valid) ov_seen = 1'b1;
        end
        total++;
        if (npulse != DEPTH || !pos_ok) begin bad++; $display("FAIL flush_pulses: got %0d (spacing ok=%b) expected %0d at 2-cycle spacing", npulse, pos_ok, DEPTH); end
        total++;
        if (din_bad || ov_seen) begin bad++; $display("FAIL flush_side: got din_nonzero=%b out_valid_seen=%b expected 0 0", din_bad, ov_seen); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle: got busy=%b expected 0", busy); end
        mdl_chain = 8'h00;
        run_byte(8'h5A, 0, 1'b0);
    endtask

    task automatic test_flush_priority();
        int npulse, first_ov;
        bit ok, din_bad;
        logic [7:0] got;
        cfg_div = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hC3;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL prio_in_ready: got %b expected 0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        npulse = 0; ok = 1'b0; din_bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            if (sr_shift) begin
                npulse++;
                if (sr_din !== 1'b0) din_bad = 1'b1;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (!ok || npulse != DEPTH || din_bad) begin
            bad++;
            $display("FAIL prio_flush_first: got accepted=%b pulses=%0d din_nonzero=%b expected 1 %0d 0", ok, npulse, din_bad, DEPTH);
        end
        first_ov = -1; got = '0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (out_valid && first_ov < 0) begin first_ov = k; got = out_data; end
        end
        total++;
        if (first_ov < 0 || got !== 8'h00) begin bad++; $display("FAIL prio_out_data: got %h (valid seen=%b) expected 00", got, first_ov >= 0); end
        mdl_chain = 8'hC3;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_divider();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef SISO_FLUSH_EN
        test_flush();
        test_flush_priority();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
